// File: rtl/texel_copier_pkg.sv
// Shared definitions for the texel copier: coordinate width, pixel size and FSM states.
package texel_copier_pkg;

    localparam int unsigned COORD_WIDTH     = 11;
    localparam int unsigned BYTES_PER_PIXEL = 2;
    localparam int unsigned PIXEL_SHIFT     = $clog2(BYTES_PER_PIXEL);
    localparam int unsigned COUNT_WIDTH     = 2 * COORD_WIDTH;

    typedef logic [COORD_WIDTH-1:0] coord_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CALC,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/texel_copier_pixel_addr.sv
// Registered framebuffer address: base + ((row*stride + col) << 1), plus a
// combinational out-of-range flag for (col, row) against (stride, limit).
module pixel_addr
    import texel_copier_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [COORD_WIDTH-1:0] stride,
    input  logic [COORD_WIDTH-1:0] limit,
    input  logic [COORD_WIDTH-1:0] row,
    input  logic [COORD_WIDTH-1:0] col,
    output logic [ADDR_WIDTH-1:0] adr,
    output logic                  oob
);

    logic [COUNT_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0]  byte_offset;

    // 22-bit product never overflows for 11-bit operands; the final sum wraps at ADDR_WIDTH.
    always_comb begin
        offset      = COUNT_WIDTH'(row) * COUNT_WIDTH'(stride) + COUNT_WIDTH'(col);
        byte_offset = ADDR_WIDTH'(offset) << PIXEL_SHIFT;
    end

    assign oob = (col >= stride) | (row >= limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            adr <= '0;
        end else if (load) begin
            adr <= base + byte_offset;
        end
    end

endmodule

// File: rtl/texel_copier.sv
// Copies one source texel per rasterized pixel into the destination framebuffer
// over a single-master req/ack bus; out-of-range texels are replaced by a fill colour.
module texel_copier
    import texel_copier_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  src_base,
    input  logic [ADDR_WIDTH-1:0]  dst_base,
    input  logic [COORD_WIDTH-1:0] hres,
    input  logic [COORD_WIDTH-1:0] vres,
    input  logic [DATA_WIDTH-1:0]  fill,
    input  logic [COORD_WIDTH-1:0] x,
    input  logic [COORD_WIDTH-1:0] y,
    input  logic [COORD_WIDTH-1:0] u,
    input  logic [COORD_WIDTH-1:0] v,
    input  logic                   ready,
    input  logic                   finished,
    output logic                   next,
    output logic [ADDR_WIDTH-1:0]  mem_adr,
    output logic                   mem_we,
    output logic [DATA_WIDTH-1:0]  mem_dat_w,
    input  logic [DATA_WIDTH-1:0]  mem_dat_r,
    output logic                   mem_req,
    input  logic                   mem_ack,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] pix_count
);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] src_base_q, dst_base_q;
    coord_t                hres_q, vres_q;
    coord_t                x_q, y_q, u_q, v_q;
    logic [DATA_WIDTH-1:0] fill_q, wdata;
    logic [ADDR_WIDTH-1:0] sadr, dadr;
    logic                  src_oob, dst_oob_unused;
    logic                  load_adr;

    assign load_adr = (state == ST_CALC);

    pixel_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_src_addr (
        .clk    (clk),
        .rst    (rst),
        .load   (load_adr),
        .base   (src_base_q),
        .stride (hres_q),
        .limit  (vres_q),
        .row    (v_q),
        .col    (u_q),
        .adr    (sadr),
        .oob    (src_oob)
    );

    // Destination range is the rasterizer's responsibility; its flag is not consulted.
    pixel_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_dst_addr (
        .clk    (clk),
        .rst    (rst),
        .load   (load_adr),
        .base   (dst_base_q),
        .stride (hres_q),
        .limit  (vres_q),
        .row    (y_q),
        .col    (x_q),
        .adr    (dadr),
        .oob    (dst_oob_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start) state_next = ST_WAIT;
            ST_WAIT:  if (ready) state_next = finished ? ST_DONE : ST_CALC;
            ST_CALC:  state_next = src_oob ? ST_WRITE : ST_READ;
            ST_READ:  if (mem_ack) state_next = ST_WRITE;
            ST_WRITE: if (mem_ack) state_next = ST_WAIT;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        next      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_dat_w = '0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_WAIT: begin
                busy = 1'b1;
                next = ready & ~finished;
            end
            ST_CALC: busy = 1'b1;
            ST_READ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_adr = sadr;
            end
            ST_WRITE: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_adr   = dadr;
                mem_dat_w = wdata;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_base_q <= '0;
            dst_base_q <= '0;
            hres_q     <= '0;
            vres_q     <= '0;
            fill_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            u_q        <= '0;
            v_q        <= '0;
            wdata      <= '0;
            pix_count  <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                src_base_q <= src_base;
                dst_base_q <= dst_base;
                hres_q     <= hres;
                vres_q     <= vres;
                fill_q     <= fill;
                pix_count  <= '0;
            end
            if (next) begin
                x_q <= x;
                y_q <= y;
                u_q <= u;
                v_q <= v;
            end
            if (state == ST_CALC && src_oob) begin
                wdata <= fill_q;
            end
            if (state == ST_READ && mem_ack) begin
                wdata <= mem_dat_r;
            end
            if (state == ST_WRITE && mem_ack && pix_count != '1) begin
                pix_count <= pix_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_texel_copier.sv
// Bench for texel_copier: rasterizer and memory models, single-pixel vector table,
// reset/idle corner sequences, randomized streams and a full triangle.
module tb_texel_copier;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] src_base, dst_base;
    logic [10:0] hres, vres, x, y, u, v;
    logic [15:0] fill;
    logic        ready, finished, next;
    logic [31:0] mem_adr;
    logic        mem_we;
    logic [15:0] mem_dat_w, mem_dat_r;
    logic        mem_req, mem_ack, busy, done;
    logic [21:0] pix_count;

    texel_copier #(.ADDR_WIDTH(32), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
        .hres(hres), .vres(vres), .fill(fill), .x(x), .y(y), .u(u), .v(v),
        .ready(ready), .finished(finished), .next(next), .mem_adr(mem_adr),
        .mem_we(mem_we), .mem_dat_w(mem_dat_w), .mem_dat_r(mem_dat_r),
        .mem_req(mem_req), .mem_ack(mem_ack), .busy(busy), .done(done),
        .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] tex(input logic [31:0] a);
        return (a[15:0] * 16'd37) ^ a[31:16] ^ 16'h5A3C;
    endfunction

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Rasterizer model: presents queued pixels, pops one per observed next.
    typedef struct packed {
        logic [10:0] x, y, u, v;
    } pix_t;

    pix_t        ras_q[$];
    pix_t        job_q[$];
    bit          ras_idle = 1'b1;
    int unsigned init_wait = 0;
    int unsigned gap_pct = 0;
    bit          took;

    initial begin
        ready = 1'b1; finished = 1'b1;
        x = '0; y = '0; u = '0; v = '0;
        forever begin
            @(negedge clk);
            took = (next === 1'b1);
            @(posedge clk);
            #1;
            if (took && ras_q.size() > 0) void'(ras_q.pop_front());
            if (ras_idle) begin
                ready = 1'b1; finished = 1'b1;
            end else if (init_wait > 0) begin
                init_wait--;
                ready = 1'b0; finished = 1'b0;
            end else if (ras_q.size() > 0) begin
                finished = 1'b0;
                ready = ($urandom_range(99) >= gap_pct);
                {x, y, u, v} = ras_q[0];
            end else begin
                ready = 1'b1; finished = 1'b1;
            end
        end
    end

    // Memory model: ack after ack_delay waiting cycles, logs every transfer.
    int unsigned ack_delay = 0;
    logic [31:0] rd_log[$];
    logic [31:0] wr_adr_log[$];
    logic [15:0] wr_dat_log[$];
    int unsigned wr_cyc_log[$];
    int unsigned stab_err = 0, drop_err = 0;
    int unsigned wcnt = 0;
    bit          have_prev = 1'b0, drop_due = 1'b0;
    logic [31:0] p_adr;
    logic        p_we;
    logic [15:0] p_dat;

    initial begin
        mem_ack = 1'b0; mem_dat_r = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack = 1'b0;
            mem_dat_r = 16'($urandom);
            if (mem_req !== 1'b1) begin
                wcnt = 0; have_prev = 1'b0; drop_due = 1'b0;
            end else begin
                if (drop_due) drop_err++;
                drop_due = 1'b0;
                if (have_prev && (mem_adr !== p_adr || mem_we !== p_we ||
                                  (mem_we && mem_dat_w !== p_dat))) stab_err++;
                if (wcnt >= ack_delay) begin
                    mem_ack = 1'b1; wcnt = 0; have_prev = 1'b0;
                    if (mem_we) begin
                        wr_adr_log.push_back(mem_adr);
                        wr_dat_log.push_back(mem_dat_w);
                        wr_cyc_log.push_back(cyc);
                        drop_due = 1'b1;
                    end else begin
                        rd_log.push_back(mem_adr);
                        mem_dat_r = tex(mem_adr);
                    end
                end else begin
                    wcnt++; have_prev = 1'b1;
                    p_adr = mem_adr; p_we = mem_we; p_dat = mem_dat_w;
                end
            end
        end
    end

    int unsigned next_cnt = 0, done_cnt = 0, done_cyc = 0;
    int unsigned nx_cyc_log[$];
    always @(negedge clk) begin
        if (next === 1'b1) begin
            next_cnt++;
            nx_cyc_log.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_logs;
        rd_log.delete(); wr_adr_log.delete(); wr_dat_log.delete(); wr_cyc_log.delete();
        nx_cyc_log.delete();
        next_cnt = 0; done_cnt = 0;
    endtask

    // Runs job_q as one triangle and checks the bus traffic against the reference model.
    task automatic run_job(input logic [31:0] sb, input logic [31:0] db, input logic [10:0] h,
                           input logic [10:0] vr, input logic [15:0] f, input bit poke,
                           input string tag);
        pix_t              jq[$];
        int unsigned       n, waited;
        logic [31:0]       e_radr[$], e_wadr[$];
        logic [15:0]       e_wdat[$];
        longint unsigned   soff, doff;
        logic [31:0]       sa;
        jq = job_q;
        n = jq.size();
        clear_logs();
        foreach (jq[i]) begin
            doff = (64'(jq[i].y) * 64'(h) + 64'(jq[i].x)) * 2;
            soff = (64'(jq[i].v) * 64'(h) + 64'(jq[i].u)) * 2;
            sa = 32'(64'(sb) + soff);
            e_wadr.push_back(32'(64'(db) + doff));
            if (jq[i].u >= h || jq[i].v >= vr) begin
                e_wdat.push_back(f);
            end else begin
                e_radr.push_back(sa);
                e_wdat.push_back(tex(sa));
            end
        end
        tick;
        src_base = sb; dst_base = db; hres = h; vres = vr; fill = f; start = 1'b1;
        ras_q = jq; init_wait = 2; ras_idle = 1'b0;
        tick;
        start = 1'b0;
        chk($sformatf("%s busy after start", tag), 64'(busy), 64'(1));
        waited = 0;
        while (done_cnt == 0 && waited < 4000) begin
            tick;
            waited++;
            if (poke && waited == 15) begin
                start = 1'b1; src_base = ~sb; dst_base = ~db; hres = h + 11'd1;
            end
            if (poke && waited == 16) start = 1'b0;
        end
        repeat (3) tick;
        ras_idle = 1'b1;
        chk($sformatf("%s done once", tag), 64'(done_cnt), 64'(1));
        chk($sformatf("%s busy after done", tag), 64'(busy), 64'(0));
        chk($sformatf("%s next count", tag), 64'(next_cnt), 64'(n));
        chk($sformatf("%s pix_count", tag), 64'(pix_count), 64'(n));
        chk($sformatf("%s write count", tag), 64'(wr_adr_log.size()), 64'(n));
        chk($sformatf("%s read count", tag), 64'(rd_log.size()), 64'(e_radr.size()));
        for (int i = 0; i < int'(n) && i < wr_adr_log.size(); i++) begin
            chk($sformatf("%s wr adr[%0d]", tag, i), 64'(wr_adr_log[i]), 64'(e_wadr[i]));
            chk($sformatf("%s wr dat[%0d]", tag, i), 64'(wr_dat_log[i]), 64'(e_wdat[i]));
        end
        for (int i = 0; i < e_radr.size() && i < rd_log.size(); i++)
            chk($sformatf("%s rd adr[%0d]", tag, i), 64'(rd_log[i]), 64'(e_radr[i]));
        if (n > 0 && wr_cyc_log.size() > 0)
            chk($sformatf("%s done latency", tag), 64'(done_cyc - wr_cyc_log[$]), 64'(2));
    endtask

    typedef struct {
        logic [10:0] x, y, u, v, h, vr;
        logic [31:0] sb, db;
        logic [15:0] f;
        bit          rd;
        logic [31:0] radr, wadr;
    } vec_t;

    vec_t        vt[7];
    int unsigned waited, busy_seen, ax, ay;
    logic [10:0] rh, rv;
    string       tg;

    function automatic int edgef(input int ax0, input int ay0, input int bx, input int by,
                                 input int px, input int py);
        return (bx - ax0) * (py - ay0) - (by - ay0) * (px - ax0);
    endfunction

    initial begin
        vt[0] = '{11'd5, 11'd2, 11'd1, 11'd1, 11'd640, 11'd480, 32'h1000, 32'h8000, 16'h1234, 1'b1, 32'h1502, 32'h8A0A};
        vt[1] = '{11'd3, 11'd0, 11'd700, 11'd0, 11'd640, 11'd480, 32'h1000, 32'h8000, 16'hF81F, 1'b0, 32'h0, 32'h8006};
        vt[2] = '{11'd3, 11'd7, 11'd0, 11'd0, 11'd0, 11'd480, 32'h2000, 32'h4000, 16'h07E0, 1'b0, 32'h0, 32'h4006};
        vt[3] = '{11'd1, 11'd1, 11'd10, 11'd480, 11'd640, 11'd480, 32'h1000, 32'h8000, 16'h00FF, 1'b0, 32'h0, 32'h8502};
        vt[4] = '{11'd0, 11'd0, 11'd639, 11'd479, 11'd640, 11'd480, 32'h1000, 32'h8000, 16'h1111, 1'b1, 32'h96FFE, 32'h8000};
        vt[5] = '{11'd2047, 11'd2047, 11'd0, 11'd0, 11'd2047, 11'd1, 32'h0, 32'hFFFF_FFF0, 16'h2222, 1'b1, 32'h0, 32'h007F_EFF0};
        vt[6] = '{11'd0, 11'd0, 11'd640, 11'd0, 11'd640, 11'd480, 32'h1000, 32'h8000, 16'hABCD, 1'b0, 32'h0, 32'h8000};

        rst = 1'b1; start = 1'b0; src_base = '0; dst_base = '0;
        hres = '0; vres = '0; fill = '0;
        repeat (3) tick;
        chk("reset next", 64'(next), 64'(0));
        chk("reset mem_req", 64'(mem_req), 64'(0));
        chk("reset mem_we", 64'(mem_we), 64'(0));
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset mem_adr", 64'(mem_adr), 64'(0));
        chk("reset mem_dat_w", 64'(mem_dat_w), 64'(0));
        chk("reset pix_count", 64'(pix_count), 64'(0));
        rst = 1'b0;

        // Idle rasterizer reports ready & finished; nothing may happen without start.
        clear_logs();
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (busy === 1'b1) busy_seen++;
        end
        chk("idle next", 64'(next_cnt), 64'(0));
        chk("idle done", 64'(done_cnt), 64'(0));
        chk("idle busy", 64'(busy_seen), 64'(0));

        ack_delay = 0; gap_pct = 0;
        for (int i = 0; i < 7; i++) begin
            job_q.delete();
            job_q.push_back({vt[i].x, vt[i].y, vt[i].u, vt[i].v});
            tg = $sformatf("vec%0d", i);
            run_job(vt[i].sb, vt[i].db, vt[i].h, vt[i].vr, vt[i].f, 1'b0, tg);
            chk({tg, " reads"}, 64'(rd_log.size()), 64'(vt[i].rd));
            if (vt[i].rd && rd_log.size() > 0)
                chk({tg, " read adr"}, 64'(rd_log[0]), 64'(vt[i].radr));
            if (wr_adr_log.size() > 0) begin
                chk({tg, " write adr"}, 64'(wr_adr_log[0]), 64'(vt[i].wadr));
                chk({tg, " write dat"}, 64'(wr_dat_log[0]),
                    64'(vt[i].rd ? tex(vt[i].radr) : vt[i].f));
                if (nx_cyc_log.size() > 0)
                    chk({tg, " pixel latency"}, 64'(wr_cyc_log[0] - nx_cyc_log[0]),
                        64'(vt[i].rd ? 3 : 2));
            end
        end

        // Reset while the second pixel's read is pending.
        job_q.delete();
        job_q.push_back({11'd1, 11'd1, 11'd2, 11'd2});
        job_q.push_back({11'd2, 11'd1, 11'd3, 11'd2});
        ack_delay = 40;
        tick;
        src_base = 32'h1000; dst_base = 32'h8000; hres = 11'd640; vres = 11'd480; fill = '0;
        start = 1'b1; ras_q = job_q; init_wait = 0; ras_idle = 1'b0;
        tick;
        start = 1'b0;
        waited = 0;
        while (!(mem_req === 1'b1 && mem_we === 1'b0 && pix_count == 22'd1) && waited < 1000) begin
            tick;
            waited++;
        end
        chk("midread reached", 64'(waited < 1000), 64'(1));
        rst = 1'b1;
        tick;
        chk("midread req", 64'(mem_req), 64'(0));
        chk("midread busy", 64'(busy), 64'(0));
        chk("midread pix_count", 64'(pix_count), 64'(0));
        rst = 1'b0; ras_idle = 1'b1; ras_q.delete(); ack_delay = 0;
        tick;
        job_q.delete();
        job_q.push_back({vt[0].x, vt[0].y, vt[0].u, vt[0].v});
        run_job(vt[0].sb, vt[0].db, vt[0].h, vt[0].vr, vt[0].f, 1'b0, "restart");

        // Random streams with ready gaps and delayed acks.
        for (int r = 0; r < 3; r++) begin
            rh = 11'($urandom_range(700, 1));
            rv = 11'($urandom_range(500, 1));
            job_q.delete();
            for (int k = 0; k < 12; k++)
                job_q.push_back({11'($urandom_range(2047)), 11'($urandom_range(2047)),
                                 11'($urandom_range(int'(rh) + 20)),
                                 11'($urandom_range(int'(rv) + 10))});
            ack_delay = (r == 0) ? 3 : r - 1;
            gap_pct = 40;
            run_job(32'($urandom), 32'($urandom), rh, rv, 16'($urandom), 1'b0,
                    $sformatf("rand%0d", r));
        end

        // Triangle A(10,10) B(5,20) C(15,20); a start pulse mid-run must be ignored.
        job_q.delete();
        for (int py = 10; py <= 20; py++)
            for (int px = 5; px <= 15; px++) begin
                int e0, e1, e2;
                e0 = edgef(10, 10, 5, 20, px, py);
                e1 = edgef(5, 20, 15, 20, px, py);
                e2 = edgef(15, 20, 10, 10, px, py);
                if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0))
                    job_q.push_back({11'(px), 11'(py), 11'(px - 5), 11'(py - 10)});
            end
        ack_delay = 0; gap_pct = 30;
        run_job(32'h0010_0000, 32'h0020_0000, 11'd64, 11'd16, 16'hFFFF, 1'b1, "tri");

        chk("bus stable while req", 64'(stab_err), 64'(0));
        chk("req drop after write ack", 64'(drop_err), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
